// File: rtl/ff_bank_pkg.sv
// Shared encodings for the flip-flop bank: bank modes and RS conflict policies.
package ff_bank_pkg;

   // Bank operating mode, sampled on every enabled edge.
   typedef enum logic [1:0] {
      ModeRs = 2'd0,
      ModeJk = 2'd1,
      ModeD  = 2'd2,
      ModeT  = 2'd3
   } mode_e;

   // Outcome of S=R=1 in RS mode.
   localparam int unsigned RsPolicyHold  = 0;
   localparam int unsigned RsPolicySet   = 1;
   localparam int unsigned RsPolicyReset = 2;

endpackage

// File: rtl/ff_cell.sv
// Next-state function of one flip-flop channel; purely combinational.
module ff_cell
   import ff_bank_pkg::*;
#(
   parameter int unsigned RS_POLICY = RsPolicyHold
) (
   input  logic [1:0] mode,
   input  logic       a,
   input  logic       b,
   input  logic       q,
   output logic       d
);

   // Decode the channel's next value from the current mode and inputs.
   always_comb begin
      d = q;
      unique case (mode_e'(mode))
         ModeRs: begin
            unique case ({a, b})
               2'b10:   d = 1'b1;
               2'b01:   d = 1'b0;
               2'b11: begin
                  if (RS_POLICY == RsPolicySet) begin
                     d = 1'b1;
                  end else if (RS_POLICY == RsPolicyReset) begin
                     d = 1'b0;
                  end else begin
                     d = q;
                  end
               end
               default: d = q;
            endcase
         end
         ModeJk: begin
            unique case ({a, b})
               2'b10:   d = 1'b1;
               2'b01:   d = 1'b0;
               2'b11:   d = ~q;
               default: d = q;
            endcase
         end
         ModeD:   d = a;
         ModeT:   d = q ^ a;
         default: d = q;
      endcase
   end

endmodule

// File: rtl/ff_bank.sv
// Bank of WIDTH configurable flip-flops with sticky RS-conflict flags and a
// saturating conflict counter.
module ff_bank
   import ff_bank_pkg::*;
#(
   parameter int unsigned       WIDTH     = 8,
   parameter logic [WIDTH-1:0]  RST_VAL   = '0,
   parameter int unsigned       RS_POLICY = RsPolicyHold,
   parameter int unsigned       CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             clr_flag,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic [WIDTH-1:0] conflict,
   output logic             conflict_any,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   logic [WIDTH-1:0] q_q, q_d, cell_d;
   logic [WIDTH-1:0] conflict_q, conflict_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hit;
   logic             hit_any;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      ff_cell #(
         .RS_POLICY (RS_POLICY)
      ) u_cell (
         .mode (mode),
         .a    (a[i]),
         .b    (b[i]),
         .q    (q_q[i]),
         .d    (cell_d[i])
      );
   end

   // Detect this edge's conflicts and compute channel/flag/counter next state.
   always_comb begin
      hit     = (en && (mode == ModeRs)) ? (a & b) : '0;
      hit_any = |hit;
      q_d     = en ? cell_d : q_q;
      // A new conflict in the same cycle as a clear survives the clear.
      if (clr_flag) begin
         conflict_d = hit;
         cnt_d      = hit_any ? CntOne : '0;
      end else begin
         conflict_d = conflict_q | hit;
         cnt_d      = cnt_q;
         if (hit_any && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntOne;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q        <= RST_VAL;
         conflict_q <= '0;
         cnt_q      <= '0;
      end else begin
         q_q        <= q_d;
         conflict_q <= conflict_d;
         cnt_q      <= cnt_d;
      end
   end

   // Outputs derive from registers only; no path from a or b.
   always_comb begin
      q            = q_q;
      qb           = ~q_q;
      conflict     = conflict_q;
      conflict_any = |conflict_q;
      conflict_cnt = cnt_q;
   end

endmodule

// File: tb/tb_ff_bank.sv
// Directed bench for ff_bank: two instances share stimulus, one with
// set-priority and one with reset-priority RS conflict policy.
module tb_ff_bank;
   import ff_bank_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [1:0] mode;
   logic [7:0] a, b;
   logic       clr_flag;

   logic [7:0] q0, qb0, cf0, cnt0;
   logic       any0;
   logic [7:0] q1, qb1, cf1, cnt1;
   logic       any1;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   ff_bank #(
      .WIDTH     (8),
      .RST_VAL   (8'h00),
      .RS_POLICY (RsPolicySet),
      .CNT_W     (8)
   ) dut_set (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .mode         (mode),
      .a            (a),
      .b            (b),
      .clr_flag     (clr_flag),
      .q            (q0),
      .qb           (qb0),
      .conflict     (cf0),
      .conflict_any (any0),
      .conflict_cnt (cnt0)
   );

   ff_bank #(
      .WIDTH     (8),
      .RST_VAL   (8'h00),
      .RS_POLICY (RsPolicyReset),
      .CNT_W     (8)
   ) dut_rst (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .mode         (mode),
      .a            (a),
      .b            (b),
      .clr_flag     (clr_flag),
      .q            (q1),
      .qb           (qb1),
      .conflict     (cf1),
      .conflict_any (any1),
      .conflict_cnt (cnt1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then return at the following falling edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b1; en = 1'b0; mode = ModeRs; a = '0; b = '0; clr_flag = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      check("rst_q", q0, 8'h00);
      check("rst_qb", qb0, 8'hFF);
      check("rst_conflict", cf0, 8'h00);
      check("rst_any", any0, 1'b0);
      check("rst_cnt", cnt0, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // RS set/clear without conflict
      en = 1'b1; mode = ModeRs; a = 8'h0F; b = 8'hF0;
      step(1);
      check("rs_q", q0, 8'h0F);
      check("rs_qb", qb0, 8'hF0);
      check("rs_conflict", cf0, 8'h00);
      a = 8'h00; b = 8'hFF;
      step(1);
      check("rs_clear_q", q0, 8'h00);

      // RS conflict under both policies
      a = 8'h03; b = 8'h03;
      step(1);
      check("pol_set_q", q0, 8'h03);
      check("pol_set_conflict", cf0, 8'h03);
      check("pol_set_any", any0, 1'b1);
      check("pol_set_cnt", cnt0, 8'h01);
      check("pol_rst_q", q1, 8'h00);
      check("pol_rst_conflict", cf1, 8'h03);
      check("pol_rst_cnt", cnt1, 8'h01);

      // JK toggle twice, then T mode
      mode = ModeD; a = 8'hAA; b = 8'h00;
      step(1);
      check("d_load_aa", q0, 8'hAA);
      mode = ModeJk; a = 8'hFF; b = 8'hFF;
      step(1);
      check("jk_toggle1", q0, 8'h55);
      check("jk_toggle1_b", q1, 8'h55);
      step(1);
      check("jk_toggle2", q0, 8'hAA);
      check("jk_no_conflict_cnt", cnt0, 8'h01);
      mode = ModeT; a = 8'h01; b = 8'hFF;
      step(1);
      check("t_toggle", q0, 8'hAB);
      check("t_qb", qb0, 8'h54);

      // Counter saturation
      mode = ModeRs; a = 8'h01; b = 8'h01;
      step(300);
      check("cnt_sat", cnt0, 8'hFF);
      check("cnt_sat_conflict", cf0, 8'h03);
      step(1);
      check("cnt_no_wrap", cnt0, 8'hFF);
      clr_flag = 1'b1; a = 8'h04; b = 8'h04;
      step(1);
      check("clr_with_hit_cnt", cnt0, 8'h01);
      check("clr_with_hit_conflict", cf0, 8'h04);
      a = 8'h00; b = 8'h00;
      step(1);
      check("clr_alone_cnt", cnt0, 8'h00);
      check("clr_alone_conflict", cf0, 8'h00);
      check("clr_alone_any", any0, 1'b0);
      clr_flag = 1'b0;

      // en=0 suppresses conflict detection
      en = 1'b0; a = 8'hFF; b = 8'hFF;
      #1;
      check("any_no_comb_path", any0, 1'b0);
      step(1);
      check("en0_conflict", cf0, 8'h00);
      check("en0_cnt", cnt0, 8'h00);

      // Clear acts with en=0
      en = 1'b1; a = 8'h01; b = 8'h01;
      step(1);
      check("hit_before_clr", cnt0, 8'h01);
      en = 1'b0; clr_flag = 1'b1; a = 8'h00; b = 8'h00;
      step(1);
      check("clr_en0_cnt", cnt0, 8'h00);
      check("clr_en0_conflict", cf0, 8'h00);
      clr_flag = 1'b0;

      // D mode with en gating
      en = 1'b1; mode = ModeD; a = 8'hFF;
      step(1);
      check("d_ff", q0, 8'hFF);
      en = 1'b0; a = 8'h3C;
      step(3);
      check("en0_hold", q0, 8'hFF);
      en = 1'b1;
      step(1);
      check("d_3c", q0, 8'h3C);

      // Asynchronous reset between edges, with a pending conflict
      a = 8'hFF;
      step(1);
      check("d_ff2", q0, 8'hFF);
      mode = ModeRs; a = 8'h10; b = 8'h10;
      step(1);
      check("pre_rst_cnt", cnt0, 8'h01);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_q", q0, 8'h00);
      check("async_rst_qb", qb0, 8'hFF);
      check("async_rst_cnt", cnt0, 8'h00);
      check("async_rst_any", any0, 1'b0);
      @(negedge clk);
      check("rst_hold_q", q0, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
